mips32_test_sequencer: RTL and testbench
========================================

# mips32_test_sequencer

Self-checking boot-and-run sequencer for the mips32 core. It does in hardware what the hand-written bench does with hierarchical pokes:
- loads a program image and the register seed into the core;
- pulses the core's PC/HALTED/TAKEN_BRANCH initialisation and runs the core until HALT or a timeout;
- reads back a parametrised set of registers and compares them against an expected-value ROM.

It sits between the core's debug/memory write ports and two small image ROMs, and reports pass/fail plus the first mismatch.

## Interface
- `MEM_AW`, 10: core memory / program ROM address width.
- `NREG`, 32: registers seeded (`Reg[k] = k`).
- `CHECK_N`, 6: registers checked, `R0..R(CHECK_N-1)`; range 1..NREG.
- `TIMEOUT`, 1024: maximum RUN cycles before abort.
- `clk1`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a test; sampled only in IDLE or DONE.
- `prog_len`  in  MEM_AW+1  program length in words; sampled with `start`.
- `prog_addr`  out  MEM_AW  program ROM address; 1-cycle synchronous read.
- `prog_data`  in  32  program ROM data.
- `mem_we`, `mem_addr[MEM_AW]`, `mem_wdata[32]`  out  core memory write port.
- `reg_we`, `reg_addr[5]`, `reg_wdata[32]`  out  core register write port.
- `reg_raddr`  out  5  core register read address; `reg_rdata` (in, 32) is combinational.
- `exp_addr`  out  5  expected ROM address; `exp_data` (in, 32) has 1-cycle synchronous latency.
- `core_init`  out  1  one-cycle pulse; core clears PC, HALTED, TAKEN_BRANCH.
- `core_run`  out  1  core advances only while high.
- `core_halted`  in  1  core HALTED flag.
- `busy`, `done`, `pass`, `timeout`  out  1  status.
- `fail_reg`  out  5  first mismatching register.
- `fail_got`  out  32  first mismatching value.
- `cycles`  out  32  RUN cycles consumed.

## Operation
- States: IDLE → LOAD → SEED → INIT → RUN → DUMP → DONE.
- **IDLE:** `start` → LOAD. Latch `min(prog_len, 2**MEM_AW)`. Clear `pass`, `timeout`, `fail_*` and `cycles`.
- **LOAD:** `prog_addr` counts 0..len-1.
  - Each returned word is written one cycle later: `mem_we=1`, `mem_addr` = delayed address, `mem_wdata = prog_data`.
  - Length 0 skips straight to SEED.
- **SEED:** `reg_we=1`, `reg_addr=k`, `reg_wdata=k`, for k = 0..NREG-1.
- **INIT:** `core_init=1` for exactly one cycle.
- **RUN:** `core_run=1`; `cycles` increments each RUN cycle.
  - `core_halted` sampled high → DUMP.
  - `cycles == TIMEOUT` with no halt → DONE with `timeout=1`, `pass=0`; DUMP is skipped.
  - Halt and timeout in the same cycle: halt wins.
- **DUMP:** `reg_raddr` and `exp_addr` sweep 0..CHECK_N-1.
  - `reg_rdata` is registered one cycle so it aligns with `exp_data`.
  - On the first mismatch only, capture `fail_reg` and `fail_got`. All CHECK_N registers are always compared.
  - `pass = 1` iff no mismatch.
- **DONE:** `done=1` is held. `start` here restarts at LOAD, with the same clearing as IDLE.
- `start` is ignored in every other state.
- `busy` = state not in {IDLE, DONE}.
- Write strobes never overlap: `mem_we` is high only in LOAD, `reg_we` only in SEED.

## Timing
- **Reset** (any state, including mid-LOAD or mid-RUN): state IDLE next cycle.
  - All outputs 0: `busy`, `done`, `pass`, `timeout`, strobes, `core_run`, `core_init`, addresses, `fail_*`, `cycles`.
  - No partial write is issued after reset.
- LOAD: len+1 cycles (1-cycle ROM latency); 0 cycles if len=0.
- SEED: NREG cycles. INIT: 1 cycle.
- RUN: `core_run` rises the cycle after `core_init` and falls the cycle after `core_halted` is sampled.
- DUMP: CHECK_N+1 cycles.
- `done` rises the cycle after the last compare, or after timeout.
- Total for a halting program: len + 1 + NREG + 1 + R + CHECK_N + 1 cycles, where R is the RUN count.

## Structure
- Shared package `mips32_pkg` holds:
  - the state enum;
  - opcode constant `HLT = 6'h3f`;
  - the register address width 5;
  - the word width 32.
- One sub-module, `mips32_seq_cmp`: the DUMP alignment register, first-mismatch capture and pass accumulator.
- Address counters and the FSM stay in the top.

## Test plan
- **Reset and idle:** after `rst`, hold `start=0` for 10 cycles → all outputs stay 0 and no strobes fire.
- **Add program:**
  - Stimulus: prog ROM = {2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000}, `prog_len=9`, expected ROM = {0, 10, 20, 25, 30, 55}.
  - Response: 9 `mem_we` pulses at addresses 0..8, 32 `reg_we` pulses, then `done=1` and `pass=1`.
- **Mismatch:** same program with `exp[4]=31` → `pass=0`, `fail_reg=4`, `fail_got=30`. Set `exp[5]=0` as well → `fail_reg` is still 4.
- **Timeout:** `TIMEOUT=20`, program without `fc000000` → `timeout=1`, `pass=0`, `cycles=20`, no DUMP reads.
- **Boundaries:** `prog_len=0` → no `mem_we`, SEED starts the cycle after `start`. `prog_len = 2**MEM_AW + 1` → exactly `2**MEM_AW` writes.
- **Reset mid-RUN, then restart:** assert `rst` mid-RUN → `core_run` is 0 next cycle and state is IDLE. Restart from DONE with `start` → counters clear and the second run passes identically.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared types and constants for the mips32 core and its test sequencer.
package mips32_pkg;

   localparam int REG_AW = 5;
   localparam int WORD_W = 32;

   localparam logic [5:0] HLT = 6'h3f;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEED = 3'd2,
      ST_INIT = 3'd3,
      ST_RUN  = 3'd4,
      ST_DUMP = 3'd5,
      ST_DONE = 3'd6
   } seq_state_e;

endpackage

// File: rtl/mips32_seq_cmp.sv
// Register-dump comparator: aligns the combinational register read with the
// one-cycle expected ROM, keeps the first mismatch and a running mismatch flag.
module mips32_seq_cmp
   import mips32_pkg::*;
(
   input  logic              clk1,
   input  logic              rst,
   input  logic              clear,
   input  logic              rd_valid,
   input  logic [REG_AW-1:0] rd_idx,
   input  logic [WORD_W-1:0] reg_rdata,
   input  logic [WORD_W-1:0] exp_data,
   output logic              mism_any,
   output logic [REG_AW-1:0] fail_reg,
   output logic [WORD_W-1:0] fail_got
);

   logic              vld_q, vld_d;
   logic [REG_AW-1:0] idx_q, idx_d;
   logic [WORD_W-1:0] got_q, got_d;
   logic              mism_q, mism_d;
   logic [REG_AW-1:0] fail_reg_q, fail_reg_d;
   logic [WORD_W-1:0] fail_got_q, fail_got_d;
   logic              hit_s;

   assign hit_s    = vld_q && (got_q != exp_data);
   assign mism_any = mism_q | hit_s;
   assign fail_reg = fail_reg_q;
   assign fail_got = fail_got_q;

   // Only the first mismatch is captured; later ones only keep mism_q set.
   always_comb begin
      vld_d      = rd_valid;
      idx_d      = rd_idx;
      got_d      = reg_rdata;
      mism_d     = mism_q;
      fail_reg_d = fail_reg_q;
      fail_got_d = fail_got_q;
      if (clear) begin
         vld_d      = 1'b0;
         mism_d     = 1'b0;
         fail_reg_d = '0;
         fail_got_d = '0;
      end else if (hit_s && !mism_q) begin
         mism_d     = 1'b1;
         fail_reg_d = idx_q;
         fail_got_d = got_q;
      end else begin
         mism_d     = mism_q;
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         vld_q      <= 1'b0;
         idx_q      <= '0;
         got_q      <= '0;
         mism_q     <= 1'b0;
         fail_reg_q <= '0;
         fail_got_q <= '0;
      end else begin
         vld_q      <= vld_d;
         idx_q      <= idx_d;
         got_q      <= got_d;
         mism_q     <= mism_d;
         fail_reg_q <= fail_reg_d;
         fail_got_q <= fail_got_d;
      end
   end

endmodule

// File: rtl/mips32_test_sequencer.sv
// Boot-and-run sequencer: loads program and register seed into the mips32 core,
// runs it to HLT or timeout, then checks R0..R(CHECK_N-1) against an expected ROM.
module mips32_test_sequencer
   import mips32_pkg::*;
#(
   parameter int MEM_AW  = 10,
   parameter int NREG    = 32,
   parameter int CHECK_N = 6,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              start,
   input  logic [MEM_AW:0]   prog_len,
   output logic [MEM_AW-1:0] prog_addr,
   input  logic [WORD_W-1:0] prog_data,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              reg_we,
   output logic [REG_AW-1:0] reg_addr,
   output logic [WORD_W-1:0] reg_wdata,
   output logic [REG_AW-1:0] reg_raddr,
   input  logic [WORD_W-1:0] reg_rdata,
   output logic [REG_AW-1:0] exp_addr,
   input  logic [WORD_W-1:0] exp_data,
   output logic              core_init,
   output logic              core_run,
   input  logic              core_halted,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [REG_AW-1:0] fail_reg,
   output logic [WORD_W-1:0] fail_got,
   output logic [WORD_W-1:0] cycles
);

   localparam logic [MEM_AW:0]   MAX_LEN  = {1'b1, {MEM_AW{1'b0}}};
   localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NREG - 1);
   localparam logic [REG_AW:0]   CHK_END  = (REG_AW + 1)'(CHECK_N);
   localparam logic [WORD_W-1:0] TO_LIMIT = WORD_W'(TIMEOUT);

   seq_state_e        state_q, state_d;
   logic [MEM_AW:0]   len_q, len_d;
   logic [MEM_AW:0]   ld_cnt_q, ld_cnt_d;
   logic [MEM_AW-1:0] prog_addr_q, prog_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic              reg_we_q, reg_we_d;
   logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
   logic [WORD_W-1:0] reg_wdata_q, reg_wdata_d;
   logic [REG_AW:0]   dmp_cnt_q, dmp_cnt_d;
   logic [REG_AW-1:0] reg_raddr_q, reg_raddr_d;
   logic [REG_AW-1:0] exp_addr_q, exp_addr_d;
   logic              core_init_q, core_init_d;
   logic              core_run_q, core_run_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [WORD_W-1:0] cycles_q, cycles_d;

   logic [MEM_AW:0]   len_in_s;
   logic [MEM_AW:0]   ld_nxt_s;
   logic [REG_AW-1:0] reg_nxt_s;
   logic [REG_AW:0]   dmp_nxt_s;
   logic [WORD_W-1:0] cyc_nxt_s;
   logic              cmp_clear_s;
   logic              rd_valid_s;
   logic              mism_any_s;

   assign len_in_s  = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
   assign ld_nxt_s  = ld_cnt_q + (MEM_AW + 1)'(1);
   assign reg_nxt_s = reg_addr_q + REG_AW'(1);
   assign dmp_nxt_s = dmp_cnt_q + (REG_AW + 1)'(1);
   assign cyc_nxt_s = cycles_q + 32'd1;

   mips32_seq_cmp u_cmp (
      .clk1      (clk1),
      .rst       (rst),
      .clear     (cmp_clear_s),
      .rd_valid  (rd_valid_s),
      .rd_idx    (reg_raddr_q),
      .reg_rdata (reg_rdata),
      .exp_data  (exp_data),
      .mism_any  (mism_any_s),
      .fail_reg  (fail_reg),
      .fail_got  (fail_got)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      ld_cnt_d    = ld_cnt_q;
      prog_addr_d = prog_addr_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      reg_we_d    = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      dmp_cnt_d   = dmp_cnt_q;
      reg_raddr_d = reg_raddr_q;
      exp_addr_d  = exp_addr_q;
      core_init_d = 1'b0;
      core_run_d  = 1'b0;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      cycles_d    = cycles_q;
      cmp_clear_s = 1'b0;
      rd_valid_s  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               len_d       = len_in_s;
               ld_cnt_d    = '0;
               prog_addr_d = '0;
               pass_d      = 1'b0;
               timeout_d   = 1'b0;
               cycles_d    = '0;
               cmp_clear_s = 1'b1;
               if (len_in_s == '0) begin
                  state_d     = ST_SEED;
                  reg_we_d    = 1'b1;
                  reg_addr_d  = '0;
                  reg_wdata_d = '0;
               end else begin
                  state_d     = ST_LOAD;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            // The ROM answers one cycle late, so each write trails its read.
            if (ld_cnt_q < len_q) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ld_cnt_q[MEM_AW-1:0];
               ld_cnt_d    = ld_nxt_s;
               prog_addr_d = (ld_nxt_s < len_q) ? ld_nxt_s[MEM_AW-1:0] : '0;
            end else begin
               state_d     = ST_SEED;
               mem_addr_d  = '0;
               prog_addr_d = '0;
               reg_we_d    = 1'b1;
               reg_addr_d  = '0;
               reg_wdata_d = '0;
            end
         end
         ST_SEED: begin
            if (reg_addr_q == LAST_REG) begin
               state_d     = ST_INIT;
               core_init_d = 1'b1;
               reg_addr_d  = '0;
               reg_wdata_d = '0;
            end else begin
               reg_we_d    = 1'b1;
               reg_addr_d  = reg_nxt_s;
               reg_wdata_d = {{(WORD_W - REG_AW){1'b0}}, reg_nxt_s};
            end
         end
         ST_INIT: begin
            state_d    = ST_RUN;
            core_run_d = 1'b1;
         end
         ST_RUN: begin
            cycles_d = cyc_nxt_s;
            if (core_halted) begin
               state_d     = ST_DUMP;
               dmp_cnt_d   = '0;
               reg_raddr_d = '0;
               exp_addr_d  = '0;
            end else if (cyc_nxt_s == TO_LIMIT) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end else begin
               core_run_d = 1'b1;
            end
         end
         ST_DUMP: begin
            if (dmp_cnt_q < CHK_END) begin
               rd_valid_s  = 1'b1;
               dmp_cnt_d   = dmp_nxt_s;
               reg_raddr_d = (dmp_nxt_s < CHK_END) ? dmp_nxt_s[REG_AW-1:0] : '0;
               exp_addr_d  = (dmp_nxt_s < CHK_END) ? dmp_nxt_s[REG_AW-1:0] : '0;
            end else begin
               state_d     = ST_DONE;
               pass_d      = ~mism_any_s;
               reg_raddr_d = '0;
               exp_addr_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         ld_cnt_q    <= '0;
         prog_addr_q <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         reg_we_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         dmp_cnt_q   <= '0;
         reg_raddr_q <= '0;
         exp_addr_q  <= '0;
         core_init_q <= 1'b0;
         core_run_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         cycles_q    <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         ld_cnt_q    <= ld_cnt_d;
         prog_addr_q <= prog_addr_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         reg_we_q    <= reg_we_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         dmp_cnt_q   <= dmp_cnt_d;
         reg_raddr_q <= reg_raddr_d;
         exp_addr_q  <= exp_addr_d;
         core_init_q <= core_init_d;
         core_run_q  <= core_run_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         cycles_q    <= cycles_d;
      end
   end

   assign prog_addr = prog_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_we_q ? prog_data : '0;
   assign reg_we    = reg_we_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_raddr = reg_raddr_q;
   assign exp_addr  = exp_addr_q;
   assign core_init = core_init_q;
   assign core_run  = core_run_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign timeout   = timeout_q;
   assign cycles    = cycles_q;

endmodule

// File: tb/tb_mips32_test_sequencer.sv
// Scoreboard bench for mips32_test_sequencer with a tiny behavioural core,
// a program ROM and an expected-value ROM.
module tb_mips32_test_sequencer;
   import mips32_pkg::*;

   localparam int MEM_AW  = 10;
   localparam int NREG    = 32;
   localparam int CHECK_N = 6;
   localparam int TIMEOUT = 20;
   localparam int MEM_N   = 1 << MEM_AW;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic        pass_v;
      logic        to_v;
      logic [31:0] freg;
      logic [31:0] fgot;
      logic [31:0] cyc;
      logic [31:0] delay;
      logic [31:0] seed_delay;
   } res_t;

   logic              clk1 = 1'b0;
   logic              rst, start, wipe;
   logic [MEM_AW:0]   prog_len;
   logic [MEM_AW-1:0] prog_addr, mem_addr;
   logic [31:0]       prog_data, mem_wdata, reg_wdata, reg_rdata, exp_data, fail_got, cycles;
   logic              mem_we, reg_we, core_init, core_run, core_halted;
   logic              busy, done, pass, timeout;
   logic [4:0]        reg_addr, reg_raddr, exp_addr, fail_reg;
   logic              any_out;

   logic [31:0] prog_rom [MEM_N];
   logic [31:0] exp_rom  [32];
   logic [31:0] add_img  [9];
   logic [31:0] core_mem [MEM_N];
   logic [31:0] core_reg [32];
   logic [MEM_AW-1:0] pc;
   logic        halted;
   logic [31:0] ir, simm;
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;

   int n_cmp = 0, n_bad = 0;
   int tick = 0, t_start = 0, seed_tick = 0, done_cnt = 0;
   wr_t  mem_q[$];
   wr_t  reg_q[$];
   res_t res_q[$];

   always #5 clk1 = ~clk1;

   mips32_test_sequencer #(
      .MEM_AW(MEM_AW), .NREG(NREG), .CHECK_N(CHECK_N), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk1(clk1), .rst(rst), .start(start), .prog_len(prog_len),
      .prog_addr(prog_addr), .prog_data(prog_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
      .exp_addr(exp_addr), .exp_data(exp_data),
      .core_init(core_init), .core_run(core_run), .core_halted(core_halted),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .fail_reg(fail_reg), .fail_got(fail_got), .cycles(cycles)
   );

   assign any_out = |{busy, done, pass, timeout, mem_we, mem_addr, mem_wdata, reg_we, reg_addr,
                      reg_wdata, reg_raddr, exp_addr, core_init, core_run, prog_addr,
                      fail_reg, fail_got, cycles};

   always @(posedge clk1) tick <= tick + 1;

   always @(posedge clk1) begin
      prog_data <= prog_rom[prog_addr];
      exp_data  <= exp_rom[exp_addr];
   end

   assign ir          = core_mem[pc];
   assign op          = ir[31:26];
   assign rs          = ir[25:21];
   assign rt          = ir[20:16];
   assign rd          = ir[15:11];
   assign simm        = {{16{ir[15]}}, ir[15:0]};
   assign reg_rdata   = core_reg[reg_raddr];
   assign core_halted = halted;

   // Minimal single-cycle core: ADD, OR, ADDI, HLT; anything else is a no-op.
   always @(posedge clk1) begin
      if (wipe) begin
         for (int i = 0; i < MEM_N; i++) core_mem[i] <= 32'd0;
         for (int j = 0; j < 32; j++) core_reg[j] <= 32'd0;
         pc     <= '0;
         halted <= 1'b0;
      end else begin
         if (mem_we) core_mem[mem_addr] <= mem_wdata;
         if (reg_we) core_reg[reg_addr] <= reg_wdata;
         if (core_init) begin
            pc     <= '0;
            halted <= 1'b0;
         end else if (core_run && !halted) begin
            pc <= pc + 1'b1;
            case (op)
               6'h00:   if (rd != 5'd0) core_reg[rd] <= core_reg[rs] + core_reg[rt];
               6'h03:   if (rd != 5'd0) core_reg[rd] <= core_reg[rs] | core_reg[rt];
               6'h0a:   if (rt != 5'd0) core_reg[rt] <= core_reg[rs] + simm;
               HLT:     halted <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: pops the scoreboard whenever the DUT writes or finishes.
   initial begin
      wr_t  e;
      res_t r;
      logic done_d1;
      done_d1 = 1'b0;
      forever begin
         @(negedge clk1);
         if (mem_we === 1'b1) begin
            if (mem_q.size() == 0) check("mem_we_unexpected", 32'd1, 32'd0);
            else begin
               e = mem_q.pop_front();
               check("mem_addr", 32'(mem_addr), e.addr);
               check("mem_wdata", mem_wdata, e.data);
            end
         end
         if (reg_we === 1'b1) begin
            if (reg_addr == 5'd0) seed_tick = tick;
            if (reg_q.size() == 0) check("reg_we_unexpected", 32'd1, 32'd0);
            else begin
               e = reg_q.pop_front();
               check("reg_addr", 32'(reg_addr), e.addr);
               check("reg_wdata", reg_wdata, e.data);
            end
         end
         if (mem_we === 1'b1 && reg_we === 1'b1) check("strobe_overlap", 32'd1, 32'd0);
         if (done === 1'b1 && !done_d1) begin
            done_cnt++;
            if (res_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
            else begin
               r = res_q.pop_front();
               check("pass", 32'(pass), 32'(r.pass_v));
               check("timeout", 32'(timeout), 32'(r.to_v));
               check("fail_reg", 32'(fail_reg), r.freg);
               check("fail_got", fail_got, r.fgot);
               check("cycles", cycles, r.cyc);
               check("done_latency", 32'(tick - t_start), r.delay);
               check("seed_latency", 32'(seed_tick - t_start), r.seed_delay);
               check("mem_writes_left", 32'(mem_q.size()), 32'd0);
               check("reg_writes_left", 32'(reg_q.size()), 32'd0);
            end
         end
         done_d1 = done;
      end
   end

   task automatic start_test(input int len_in, input logic exp_pass, input logic exp_to,
                             input int freg, input int fgot, input int r_cnt);
      res_t r;
      int   len_eff;
      int   load_cyc;
      len_eff  = (len_in > MEM_N) ? MEM_N : len_in;
      load_cyc = (len_eff == 0) ? 0 : len_eff + 1;
      for (int i = 0; i < len_eff; i++) mem_q.push_back('{addr: 32'(i), data: prog_rom[i]});
      for (int k = 0; k < NREG; k++) reg_q.push_back('{addr: 32'(k), data: 32'(k)});
      r.pass_v     = exp_pass;
      r.to_v       = exp_to;
      r.freg       = 32'(freg);
      r.fgot       = 32'(fgot);
      r.cyc        = 32'(r_cnt);
      r.seed_delay = 32'(load_cyc);
      r.delay      = 32'(load_cyc + NREG + 1 + r_cnt + (exp_to ? 0 : CHECK_N + 1));
      res_q.push_back(r);
      @(negedge clk1);
      prog_len = (MEM_AW + 1)'(len_in);
      start    = 1'b1;
      @(negedge clk1);
      start   = 1'b0;
      t_start = tick;
      check("start_busy", 32'(busy), 32'd1);
      check("start_clear", 32'(|{done, pass, timeout, fail_reg, fail_got, cycles}), 32'd0);
   endtask

   task automatic wait_done();
      int c0;
      int n;
      c0 = done_cnt;
      n  = 0;
      while (done_cnt == c0 && n < 3000) begin
         @(negedge clk1);
         n++;
      end
      if (done_cnt == c0) check("done_wait", 32'd0, 32'd1);
   endtask

   task automatic load_add_image();
      for (int i = 0; i < MEM_N; i++) prog_rom[i] = (i < 9) ? add_img[i] : 32'd0;
   endtask

   initial begin
      int n;
      add_img = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                  32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
      for (int i = 0; i < 32; i++) exp_rom[i] = 32'd0;
      exp_rom[1] = 32'd10; exp_rom[2] = 32'd20; exp_rom[3] = 32'd25;
      exp_rom[4] = 32'd30; exp_rom[5] = 32'd55;
      load_add_image();
      rst = 1'b1; wipe = 1'b1; start = 1'b0; prog_len = '0;
      repeat (3) @(negedge clk1);
      wipe = 1'b0;
      rst  = 1'b0;

      // Idle after reset: nothing moves.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk1);
         check("idle_outputs", 32'(any_out), 32'd0);
      end

      start_test(9, 1'b1, 1'b0, 0, 0, 10);
      wait_done();

      // Zero length reuses the image already in core memory.
      start_test(0, 1'b1, 1'b0, 0, 0, 10);
      wait_done();

      exp_rom[4] = 32'd31;
      start_test(9, 1'b0, 1'b0, 4, 30, 10);
      wait_done();
      exp_rom[5] = 32'd0;
      start_test(9, 1'b0, 1'b0, 4, 30, 10);
      wait_done();
      exp_rom[4] = 32'd30;
      exp_rom[5] = 32'd55;

      prog_rom[8] = 32'd0;
      start_test(9, 1'b0, 1'b1, 0, 0, TIMEOUT);
      wait_done();

      for (int i = 0; i < MEM_N; i++) prog_rom[i] = {6'h3e, 26'(i)};
      start_test(MEM_N + 1, 1'b0, 1'b1, 0, 0, TIMEOUT);
      wait_done();

      load_add_image();
      start_test(9, 1'b1, 1'b0, 0, 0, 10);
      n = 0;
      while (core_run !== 1'b1 && n < 200) begin
         @(negedge clk1);
         n++;
      end
      check("reach_run", 32'(core_run), 32'd1);
      repeat (3) @(negedge clk1);
      rst = 1'b1;
      @(negedge clk1);
      rst = 1'b0;
      check("rst_core_run", 32'(core_run), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_outputs", 32'(any_out), 32'd0);
      res_q.delete();

      start_test(9, 1'b1, 1'b0, 0, 0, 10);
      wait_done();
      start_test(9, 1'b1, 1'b0, 0, 0, 10);
      wait_done();
      repeat (3) @(negedge clk1);
      check("done_held", 32'(done), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
